uart_tx_serializer: RTL

- UART transmit engine that sits directly downstream of the transmit FIFO (tfifo).
- Pops one byte at a time through the FIFO's re/d_ready handshake and serialises it onto txd_o as a start bit, DATA_WIDTH data bits (LSB first), optional parity and 1 or 2 stop bits.
- Drives the FIFO's tr_bz input so the FIFO never pops while a frame is on the line.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/uart_tx_serializer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and the future receiver).
package uart_pkg;

  // 50 MHz system clock at 115200 baud.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  // Widest data word parity_f accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int unsigned PARITY_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_f(input logic [PARITY_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit with tick_o. Shared by the transmitter and receiver.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  // Count while enabled; restart on every bit boundary so the counter never
  // wraps mid-bit, and hold at zero whenever cleared.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine sitting behind the transmit FIFO. Pops one byte per
// frame through the FIFO re/d_ready handshake and shifts it out LSB first.
//
// state  | meaning
// IDLE   | line idle high, waiting for tx_en_i and a non-empty FIFO
// REQ    | one-cycle pop request to the FIFO (busy low so the pop is taken)
// WAIT   | check d_ready: load the byte and go on, or drop back to IDLE
// START  | start bit (low)
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | optional parity bit
// STOP   | STOP_BITS stop bits (high), done pulse on the very last cycle
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  tx_en_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_dvalid_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_re_o,
  output logic                  tx_busy_o,
  output logic                  txd_o,
  output logic                  tx_done_o
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  tx_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  par_q, par_d;
  logic                  baud_tick;

  // The bit timer only runs while a frame is on the line and sits at zero
  // otherwise, so START always gets a full bit period.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (!tx_busy_o),
    .en_i   (tx_busy_o),
    .tick_o (baud_tick)
  );

  // State, shift register, bit counter and parity register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
    end
  end

  // Next-state and output decode; all outputs are decoded from the state so
  // an asynchronous reset returns the line to idle-high immediately.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    par_d     = par_q;
    fifo_re_o = 1'b0;
    tx_busy_o = 1'b0;
    tx_done_o = 1'b0;
    txd_o     = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (tx_en_i && !fifo_empty_i) begin
          state_d = REQ;
        end
      end

      REQ: begin
        fifo_re_o = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        // A missing d_ready means the FIFO dropped the pop (write collision
        // or empty); nothing was consumed, so simply retry from IDLE.
        if (fifo_dvalid_i) begin
          shift_d = fifo_data_i;
          par_d   = parity_f(PARITY_MAX_W'(fifo_data_i), PAR_ODD);
          bit_d   = '0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        tx_busy_o = 1'b1;
        txd_o     = 1'b0;
        if (baud_tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        tx_busy_o = 1'b1;
        txd_o     = shift_q[0];
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      PARITY: begin
        tx_busy_o = 1'b1;
        txd_o     = par_q;
        if (baud_tick) begin
          bit_d   = '0;
          state_d = STOP;
        end
      end

      STOP: begin
        tx_busy_o = 1'b1;
        txd_o     = 1'b1;
        if (baud_tick) begin
          if (bit_q == STOP_LAST) begin
            tx_done_o = 1'b1;
            bit_d     = '0;
            state_d   = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
